ddr_cmd_scheduler: RTL and testbench
====================================

// Module: ddr_cmd_scheduler
// PURPOSE
//  Open-page DDR4 command sequencer between the controller request queue and the DIMM command/address bus.
//  Takes one RD/WR request at a time, issues PRE/ACT/RD/WR with tRP/tRCD/tRAS/CL/CWL spacing, and tracks open rows per bank.
//  Emits rd_start/wr_start data-phase strobes and no_act_rdy on row hits, which the DIMM model uses to queue addresses.
// PARAMETERS
//  T_RCD  11  ACT->CAS cycles
//  T_RP   11  PRE->ACT cycles (same bank)
//  T_RAS  28  ACT->PRE minimum cycles (per bank)
//  CL     11  RD->rd_start cycles
//  CWL     9  WR->wr_start cycles
//  T_WTR   4  extra cycles after write burst before next CAS
//  CNT_W   6  timing counter width; every T_* and CL/CWL value must be < 2**CNT_W
// PORTS
//  CK_t         in   1   clock; all logic on posedge
//  reset        in   1   asynchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   scheduler accepts request this cycle
//  req_rw       in   1   1=RD, 0=WR
//  req_bg/req_ba in  2/2 bank group / bank
//  req_row      in  14   row address
//  req_col      in  10   column address
//  bl8          in   1   1=BL8, 0=BC4; sampled with the request
//  cmd          out  5   {cs_n,act_n,RAS_n_A16,CAS_n_A15,WE_n_A14}
//  bg_addr/ba_addr out 2/2  bank address driven with cmd
//  addr         out 14   A13..A0 (row on ACT, {4'b0,col} on CAS, A10_AP=0 on PRE)
//  no_act_rdy   out  1   1-cycle pulse: row hit, CAS issued without ACT
//  rd_start     out  1   1-cycle pulse CL cycles after RD command
//  wr_start     out  1   1-cycle pulse CWL cycles after WR command
//  busy         out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: cmd=CMD_NOP, addresses 0, req_ready=0, pulses 0, busy=0, bank table cleared (all closed),
//   all counters 0, FSM=IDLE. Reset mid-sequence aborts: no pending strobe fires after release.
//  Handshake: req_ready=1 only in IDLE; transfer on req_valid&&req_ready; fields latched that edge.
//  Bank table: 16 entries {open,row}, index {bg,ba}; per-bank tRAS down-counter loaded T_RAS-1 on ACT.
//  FSM (one command per cycle, NOP otherwise):
//   IDLE     -> accept: hit (open && row==req_row) -> CAS; closed -> ACT; open other row -> PRE.
//   PRE      -> wait bank tRAS==0 before issuing; issue CMD_PRE, clear entry, load T_RP-1 -> WAIT_RP.
//   WAIT_RP  -> counter==0 -> ACT.
//   ACT      -> issue CMD_ACT (addr=row), set entry, load T_RCD-1 -> WAIT_RCD.
//   WAIT_RCD -> counter==0 -> CAS.
//   CAS      -> wait turnaround counter==0; issue CMD_RD/CMD_WR; no_act_rdy=1 same cycle if path was hit;
//               load strobe delay (CL-1 or CWL-1) -> WAIT_DATA.
//   WAIT_DATA-> strobe fires when delay reaches 0; load turnaround = BL/2 (RD) or BL/2+T_WTR (WR) -> IDLE.
//  BL/2 = 4 for BL8, 2 for BC4. Turnaround counter runs independently; a new request may be
//   accepted while it is non-zero, but the CAS is held.
//  Counters saturate at 0; no wrap. Never two commands in one cycle; hit to same row never issues PRE.
//  Row kept open after CAS (open-page); no auto-precharge, no refresh in this block.
// STRUCTURE
//  ddr_pkg: CMD_ACT=5'b00111, CMD_WR=5'b01100, CMD_RD=5'b01101, CMD_PRE=5'b01010,
//   CMD_NOP=5'b11111; typedef enum sched_state_t; typedef struct bank_entry_t {open,row}.
//  Sub-module ddr_bank_table: 16 entries + tRAS counters; lookup port, ACT-set, PRE-clear.
// TESTING
//  1 WR bg1 ba2 row 0x0123 col 0x040 BL8 from reset -> ACT@t, WR@t+11, wr_start@t+20, no PRE.
//  2 RD same bank/row next -> no ACT, no_act_rdy with RD cmd, rd_start 11 cycles later.
//  3 RD bg1 ba2 row 0x0200 -> PRE held until tRAS elapsed (>=28 after ACT), ACT 11 after PRE, RD 11 after ACT.
//  4 WR BL8 then RD other open bank -> RD CAS >= 9+4+4 cycles after WR; BC4 case uses 2.
//  5 Assert reset while in WAIT_RCD -> cmd=NOP same cycle, no rd/wr_start ever, table all closed.
//  6 req_valid held continuously -> req_ready only in IDLE, exactly one command per cycle max.

Source files
------------

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - DDR4 command encodings, scheduler states and bank entry type
package ddr_pkg;

    localparam logic [4:0] CMD_ACT = 5'b00111;
    localparam logic [4:0] CMD_WR  = 5'b01100;
    localparam logic [4:0] CMD_RD  = 5'b01101;
    localparam logic [4:0] CMD_PRE = 5'b01010;
    localparam logic [4:0] CMD_NOP = 5'b11111;

    localparam int NUM_BANKS = 16;
    localparam int ROW_W     = 14;
    localparam int COL_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_RP   = 3'd2,
        ST_ACT       = 3'd3,
        ST_WAIT_RCD  = 3'd4,
        ST_CAS       = 3'd5,
        ST_WAIT_DATA = 3'd6
    } sched_state_t;

    typedef struct packed {
        logic             open;
        logic [ROW_W-1:0] row;
    } bank_entry_t;

    function automatic logic [3:0] bank_index(input logic [1:0] bg, input logic [1:0] ba);
        return {bg, ba};
    endfunction

endpackage

// File: rtl/ddr_bank_table.sv
// rtl/ddr_bank_table.sv - per-bank open-row table with tRAS hold-off counters
module ddr_bank_table
    import ddr_pkg::*;
#(
    parameter int unsigned T_RAS = 28,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       look_idx,
    output logic             look_open,
    output logic [ROW_W-1:0] look_row,
    output logic             look_ras_done,
    input  logic             act_set,
    input  logic             pre_clr,
    input  logic [3:0]       cmd_idx,
    input  logic [ROW_W-1:0] act_row
);

    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);

    bank_entry_t      bank_q [NUM_BANKS];
    bank_entry_t      bank_d [NUM_BANKS];
    logic [CNT_W-1:0] ras_q  [NUM_BANKS];
    logic [CNT_W-1:0] ras_d  [NUM_BANKS];

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = bank_q[i];
            ras_d[i]  = (ras_q[i] == '0) ? '0 : ras_q[i] - 1'b1;
            if (cmd_idx == 4'(i)) begin
                if (act_set) begin
                    bank_d[i].open = 1'b1;
                    bank_d[i].row  = act_row;
                    ras_d[i]       = RAS_LD;
                end
                if (pre_clr) begin
                    bank_d[i].open = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= '0;
                ras_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= bank_d[i];
                ras_q[i]  <= ras_d[i];
            end
        end
    end

    assign look_open     = bank_q[look_idx].open;
    assign look_row      = bank_q[look_idx].row;
    assign look_ras_done = (ras_q[look_idx] == '0);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - open-page DDR4 PRE/ACT/CAS sequencer, one request at a time
module ddr_cmd_scheduler
    import ddr_pkg::*;
#(
    parameter int unsigned T_RCD = 11,
    parameter int unsigned T_RP  = 11,
    parameter int unsigned T_RAS = 28,
    parameter int unsigned CL    = 11,
    parameter int unsigned CWL   = 9,
    parameter int unsigned T_WTR = 4,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CK_t,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic             bl8,
    output logic [4:0]       cmd,
    output logic [1:0]       bg_addr,
    output logic [1:0]       ba_addr,
    output logic [ROW_W-1:0] addr,
    output logic             no_act_rdy,
    output logic             rd_start,
    output logic             wr_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RP_LD    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RCD_LD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CL_LD    = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] CWL_LD   = CNT_W'(CWL - 1);
    localparam logic [CNT_W-1:0] WTR_LD   = CNT_W'(T_WTR);
    localparam logic [CNT_W-1:0] BL8_HALF = CNT_W'(4);
    localparam logic [CNT_W-1:0] BC4_HALF = CNT_W'(2);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] turn_q, turn_d;
    logic             rw_q, rw_d;
    logic             bl8_q, bl8_d;
    logic             hit_q, hit_d;
    logic [3:0]       idx_q, idx_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    logic [3:0]       look_idx;
    logic             look_open;
    logic [ROW_W-1:0] look_row;
    logic             look_ras_done;
    logic             act_set;
    logic             pre_clr;
    logic [CNT_W-1:0] turn_ld;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign look_idx  = (state_q == ST_IDLE) ? bank_index(req_bg, req_ba) : idx_q;

    ddr_bank_table #(
        .T_RAS (T_RAS),
        .CNT_W (CNT_W)
    ) u_bank_table (
        .clk           (CK_t),
        .rst           (reset),
        .look_idx      (look_idx),
        .look_open     (look_open),
        .look_row      (look_row),
        .look_ras_done (look_ras_done),
        .act_set       (act_set),
        .pre_clr       (pre_clr),
        .cmd_idx       (idx_q),
        .act_row       (row_q)
    );

    // Command waits leave when the decremented count hits zero so the next command lands
    // exactly T cycles after the previous one; the data strobe fires inside WAIT_DATA itself.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        turn_d     = (turn_q == '0) ? '0 : turn_q - 1'b1;
        rw_d       = rw_q;
        bl8_d      = bl8_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        cmd        = CMD_NOP;
        bg_addr    = '0;
        ba_addr    = '0;
        addr       = '0;
        no_act_rdy = 1'b0;
        rd_start   = 1'b0;
        wr_start   = 1'b0;
        act_set    = 1'b0;
        pre_clr    = 1'b0;
        turn_ld    = (bl8_q ? BL8_HALF : BC4_HALF) + (rw_q ? '0 : WTR_LD);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rw_d  = req_rw;
                    bl8_d = bl8;
                    idx_d = bank_index(req_bg, req_ba);
                    row_d = req_row;
                    col_d = req_col;
                    hit_d = look_open && (look_row == req_row);
                    if (look_open && (look_row == req_row)) begin
                        state_d = ST_CAS;
                    end else if (look_open) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d = ST_ACT;
                    end
                end
            end
            ST_PRE: begin
                if (look_ras_done) begin
                    cmd                = CMD_PRE;
                    {bg_addr, ba_addr} = idx_q;
                    pre_clr            = 1'b1;
                    cnt_d              = RP_LD;
                    state_d            = ST_WAIT_RP;
                end
            end
            ST_WAIT_RP: begin
                if (cnt_d == '0) begin
                    state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                cmd                = CMD_ACT;
                {bg_addr, ba_addr} = idx_q;
                addr               = row_q;
                act_set            = 1'b1;
                cnt_d              = RCD_LD;
                state_d            = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (cnt_d == '0) begin
                    state_d = ST_CAS;
                end
            end
            ST_CAS: begin
                if (turn_q == '0) begin
                    cmd                = rw_q ? CMD_RD : CMD_WR;
                    {bg_addr, ba_addr} = idx_q;
                    addr               = {{(ROW_W - COL_W){1'b0}}, col_q};
                    no_act_rdy         = hit_q;
                    cnt_d              = rw_q ? CL_LD : CWL_LD;
                    state_d            = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (cnt_q == '0) begin
                    rd_start = rw_q;
                    wr_start = !rw_q;
                    turn_d   = turn_ld;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            turn_q  <= '0;
            rw_q    <= 1'b0;
            bl8_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            turn_q  <= turn_d;
            rw_q    <= rw_d;
            bl8_q   <= bl8_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb/tb_ddr_cmd_scheduler.sv - scoreboard bench for the DDR4 command scheduler
module tb_ddr_cmd_scheduler;
    import ddr_pkg::*;

    localparam int T_RCD = 11;
    localparam int T_RP  = 11;
    localparam int T_RAS = 28;
    localparam int CL    = 11;
    localparam int CWL   = 9;
    localparam int T_WTR = 4;

    logic        CK_t      = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw    = 1'b0;
    logic [1:0]  req_bg    = '0;
    logic [1:0]  req_ba    = '0;
    logic [13:0] req_row   = '0;
    logic [9:0]  req_col   = '0;
    logic        bl8       = 1'b0;
    logic        req_ready;
    logic [4:0]  cmd;
    logic [1:0]  bg_addr;
    logic [1:0]  ba_addr;
    logic [13:0] addr;
    logic        no_act_rdy;
    logic        rd_start;
    logic        wr_start;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [4:0]  code;
        logic [3:0]  idx;
        logic [13:0] addr;
        logic        nar;
    } cmd_exp_t;

    typedef struct {
        int   cyc;
        logic rd;
    } strb_exp_t;

    cmd_exp_t    cmd_sb[$];
    strb_exp_t   strb_sb[$];
    cmd_exp_t    mon_cmd;
    strb_exp_t   mon_strb;

    logic        m_open [16];
    logic [13:0] m_row  [16];
    int          m_ras  [16];
    int          last_act [16];
    int          m_turn;
    int          m_idle;
    int          strobe_seen = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    ddr_cmd_scheduler #(
        .T_RCD (T_RCD), .T_RP (T_RP), .T_RAS (T_RAS),
        .CL (CL), .CWL (CWL), .T_WTR (T_WTR), .CNT_W (6)
    ) dut (
        .CK_t       (CK_t),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_bg     (req_bg),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .bl8        (bl8),
        .cmd        (cmd),
        .bg_addr    (bg_addr),
        .ba_addr    (ba_addr),
        .addr       (addr),
        .no_act_rdy (no_act_rdy),
        .rd_start   (rd_start),
        .wr_start   (wr_start),
        .busy       (busy)
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic push_cmd(input int c, input logic [4:0] code, input logic [3:0] idx,
                            input logic [13:0] a, input logic nar);
        cmd_exp_t e;
        e.cyc = c; e.code = code; e.idx = idx; e.addr = a; e.nar = nar;
        cmd_sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0; m_row[i] = '0; m_ras[i] = 0; last_act[i] = 0;
        end
        m_turn = 0;
        m_idle = 0;
        cmd_sb.delete();
        strb_sb.delete();
    endtask

    // Predicts the command stream of a request accepted in cycle a from the timing rules.
    task automatic model_accept(input int a, input logic rw, input logic [3:0] idx,
                                input logic [13:0] row, input logic [9:0] col, input logic b8);
        int        t, c, s, p;
        logic      hit;
        strb_exp_t se;
        t   = a + 1;
        hit = m_open[idx] && (m_row[idx] == row);
        if (hit) begin
            c = imax(t, m_turn);
        end else begin
            if (m_open[idx]) begin
                p = imax(t, m_ras[idx]);
                push_cmd(p, CMD_PRE, idx, 14'h0, 1'b0);
                t = p + T_RP;
            end
            push_cmd(t, CMD_ACT, idx, row, 1'b0);
            m_ras[idx]  = t + T_RAS;
            m_open[idx] = 1'b1;
            m_row[idx]  = row;
            c = imax(t + T_RCD, m_turn);
        end
        push_cmd(c, rw ? CMD_RD : CMD_WR, idx, {4'b0, col}, hit);
        s = c + (rw ? CL : CWL);
        se.cyc = s; se.rd = rw;
        strb_sb.push_back(se);
        m_idle = s + 1;
        m_turn = s + 1 + (b8 ? 4 : 2) + (rw ? 0 : T_WTR);
    endtask

    task automatic send_req(input logic rw, input logic [1:0] bg, input logic [1:0] ba,
                            input logic [13:0] row, input logic [9:0] col, input logic b8);
        int d, n;
        d = cyc;
        n = 0;
        req_valid = 1'b1; req_rw = rw; req_bg = bg; req_ba = ba;
        req_row = row; req_col = col; bl8 = b8;
        while (!req_ready && n < 500) begin
            @(negedge CK_t);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            chk("accept_cycle", 32'(cyc), 32'(imax(d, m_idle)));
            model_accept(cyc, rw, {bg, ba}, row, col, b8);
        end
        @(negedge CK_t);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cmd_sb.size() != 0 || strb_sb.size() != 0) && n < 300) begin
            @(negedge CK_t);
            n++;
        end
        chk("drain_pending", 32'(cmd_sb.size() + strb_sb.size()), 32'd0);
        repeat (2) @(negedge CK_t);
    endtask

    always @(negedge CK_t) begin
        if (!reset) begin
            if (cmd != CMD_NOP) begin
                if (cmd_sb.size() == 0) begin
                    chk("unexpected_cmd", 32'(cmd), 32'(CMD_NOP));
                end else begin
                    mon_cmd = cmd_sb.pop_front();
                    chk("cmd_code", 32'(cmd), 32'(mon_cmd.code));
                    chk("cmd_cycle", 32'(cyc), 32'(mon_cmd.cyc));
                    chk("cmd_bank", 32'({bg_addr, ba_addr}), 32'(mon_cmd.idx));
                    chk("cmd_addr", 32'(addr), 32'(mon_cmd.addr));
                    chk("no_act_rdy", 32'(no_act_rdy), 32'(mon_cmd.nar));
                end
                if (cmd == CMD_ACT) last_act[{bg_addr, ba_addr}] = cyc;
                if (cmd == CMD_PRE)
                    chk("tras_gap", 32'((cyc - last_act[{bg_addr, ba_addr}]) >= T_RAS), 32'd1);
            end else if (no_act_rdy) begin
                chk("stray_no_act_rdy", 32'(no_act_rdy), 32'd0);
            end
            if (rd_start || wr_start) begin
                strobe_seen++;
                if (strb_sb.size() == 0) begin
                    chk("unexpected_strobe", 32'({rd_start, wr_start}), 32'd0);
                end else begin
                    mon_strb = strb_sb.pop_front();
                    chk("strobe_kind", 32'({rd_start, wr_start}), mon_strb.rd ? 32'd2 : 32'd1);
                    chk("strobe_cycle", 32'(cyc), 32'(mon_strb.cyc));
                end
            end
            if (req_ready) chk("ready_only_idle", 32'(busy), 32'd0);
        end
    end

    initial begin
        int seen0;
        logic       r_rw, r_b8;
        logic [1:0] r_bg, r_ba;
        logic [13:0] r_row;
        logic [9:0]  r_col;

        model_reset();
        repeat (3) @(negedge CK_t);
        chk("rst_cmd", 32'(cmd), 32'(CMD_NOP));
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'({bg_addr, ba_addr, addr}), 32'd0);
        chk("rst_pulses", 32'({no_act_rdy, rd_start, wr_start}), 32'd0);
        reset = 1'b0;
        @(negedge CK_t);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Closed bank write, row hit read, row miss read.
        send_req(1'b0, 2'd1, 2'd2, 14'h0123, 10'h040, 1'b1);
        req_valid = 1'b0;
        send_req(1'b1, 2'd1, 2'd2, 14'h0123, 10'h041, 1'b1);
        req_valid = 1'b0;
        send_req(1'b1, 2'd1, 2'd2, 14'h0200, 10'h010, 1'b1);
        req_valid = 1'b0;
        drain();

        // Row miss right after ACT: PRE must wait out tRAS. Valid stays high from here on.
        send_req(1'b0, 2'd0, 2'd0, 14'h0005, 10'h000, 1'b1);
        send_req(1'b1, 2'd0, 2'd0, 14'h0006, 10'h008, 1'b0);
        // Write-to-read turnaround across banks, BL8 then BC4.
        send_req(1'b0, 2'd0, 2'd0, 14'h0006, 10'h020, 1'b1);
        send_req(1'b1, 2'd1, 2'd2, 14'h0200, 10'h030, 1'b1);
        send_req(1'b0, 2'd0, 2'd0, 14'h0006, 10'h021, 1'b0);
        send_req(1'b1, 2'd1, 2'd2, 14'h0200, 10'h031, 1'b1);
        req_valid = 1'b0;
        drain();

        for (int k = 0; k < 12; k++) begin
            r_rw  = 1'($urandom_range(0, 1));
            r_b8  = 1'($urandom_range(0, 1));
            r_bg  = {1'b0, 1'($urandom_range(0, 1))};
            r_ba  = {1'($urandom_range(0, 1)), 1'b0};
            r_row = 14'h0010 + 14'($urandom_range(0, 1));
            r_col = 10'($urandom_range(0, 1023));
            send_req(r_rw, r_bg, r_ba, r_row, r_col, r_b8);
        end
        req_valid = 1'b0;
        drain();

        // Reset while waiting on tRCD aborts the sequence and closes every bank.
        send_req(1'b1, 2'd3, 2'd3, 14'h0777, 10'h005, 1'b1);
        req_valid = 1'b0;
        repeat (3) @(negedge CK_t);
        chk("busy_in_wait_rcd", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_cmd", 32'(cmd), 32'(CMD_NOP));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        model_reset();
        seen0 = strobe_seen;
        repeat (3) @(negedge CK_t);
        reset = 1'b0;
        repeat (40) @(negedge CK_t);
        chk("no_strobe_after_abort", 32'(strobe_seen - seen0), 32'd0);
        send_req(1'b1, 2'd1, 2'd2, 14'h0200, 10'h003, 1'b1);
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
